wb_intercon_arb: RTL and testbench
==================================

Name: wb_intercon_arb

Overview:
- Wishbone interconnect for the CPU subsystem: two masters (OR1200 instruction bus "or1200_i", OR1200 data bus "or1200_d") share one slave (main memory "mem").
- Contains a cycle-locked arbiter, a combinational forward/return multiplexer and an address-range check.
- Sits between or1200_top and the main RAM model.

Parameters:
- MEM_BASE, 32'h00000000, byte base address of the memory window.
- MEM_SIZE, 32'h00800000, window size in bytes; must be a power of two.

Ports:
- wb_clk_i  in  1  Wishbone clock.
- wb_rst_i  in  1  Reset, asynchronous, active-low.
- wb_or1200_i_adr_i/dat_i  in  32 each  Instruction master address / write data.
- wb_or1200_i_sel_i  in  4  Byte selects.
- wb_or1200_i_we_i/cyc_i/stb_i  in  1 each  Write enable, cycle, strobe.
- wb_or1200_i_cti_i  in  3; wb_or1200_i_bte_i  in  2  Burst tags.
- wb_or1200_i_dat_o  out  32  Read data.
- wb_or1200_i_ack_o/err_o/rty_o  out  1 each  Terminations.
- wb_or1200_d_*  Identical set for the data master.
- wb_mem_adr_o/dat_o  out  32 each; wb_mem_sel_o  out  4.
- wb_mem_we_o/cyc_o/stb_o  out  1 each; wb_mem_cti_o  out  3; wb_mem_bte_o  out  2.
- wb_mem_dat_i  in  32; wb_mem_ack_i/err_i/rty_i  in  1 each.

Behaviour:
- Grant register states: IDLE, GNT_I, GNT_D. Reset (wb_rst_i=0) forces IDLE asynchronously.
- IDLE transitions at the clock edge: d_cyc=1 -> GNT_D (data wins ties); else i_cyc=1 -> GNT_I; else stay IDLE.
- GNT_x transitions at the clock edge: while owner cyc=1, hold; this locks bursts and multi-beat cycles.
- When owner cyc=0: go to the other master's grant if that master's cyc=1, else IDLE. This alternation prevents starvation.
- Grant latency: a request in IDLE reaches the slave one cycle after cyc rises.
- Forward path is combinational from the owner: adr, dat, sel, we, cti, bte.
- wb_mem_cyc_o = owner cyc & hit; wb_mem_stb_o = owner stb & hit.
- In IDLE, all wb_mem_* outputs are 0.
- Return path: wb_mem_dat_i is broadcast to both dat_o ports. ack, err and rty are routed only to the owner; the non-owner always sees 0.
- hit = (adr - MEM_BASE) < MEM_SIZE, evaluated with 32-bit unsigned arithmetic; wrap-around below the base counts as a miss.
- Miss handling:
  - Slave cyc/stb are held 0.
  - A local registered error pulse err_r is set on the edge where owner cyc&stb&!hit&!err_r, and cleared on the next edge.
  - The owner sees err_o=1 one cycle after stb, for exactly one cycle.
  - err_r is cleared on reset and on a grant change.
- Reset mid-transfer returns to IDLE immediately. Masters must restart their cycles.
- Simultaneous release and re-request by the same master with the other idle: grant goes IDLE, then is re-granted the next cycle.

Optional Feature:
- Macro: WB_INTERCON_ADDR_CHECK_EN.
- Defined: hit decode and local err generation active as in Behaviour.
- Undefined: hit is tied to 1. Every address is forwarded to memory, err/rty come only from the slave, and the MEM_BASE/MEM_SIZE parameters are unused.

Decomposition:
- Shared package wb_intercon_pkg holds:
  - localparams WB_AW=32, WB_DW=32;
  - the grant-state enum {IDLE, GNT_I, GNT_D};
  - CTI constants CLASSIC=3'b000, INCR=3'b010, EOB=3'b111.
- One sub-module, wb_arbiter_2: grant FSM only, inputs cyc pair, outputs one-hot grant. Muxing and decode stay in the top.

Test Plan:
- Reset: hold wb_rst_i=0 with both cyc=1 -> wb_mem_cyc_o=0, all acks/errs 0; first edge after release grants data master.
- Instruction read only: i_cyc/stb=1, adr=0x100 -> one cycle later wb_mem_adr_o=0x100, stb=1; slave ack and dat=0xDEADBEEF -> i_ack_o=1, i_dat_o=0xDEADBEEF, d_ack_o=0.
- Contention: both cyc rise together -> GNT_D first. Data drops cyc after 1 ack while i_cyc is still 1 -> next cycle GNT_I with no IDLE gap.
- Burst lock: data master issues 4-beat INCR burst (cti 010,010,010,111) at 0x2000 while i_cyc=1 -> all 4 beats complete before instruction is granted.
- Out-of-range (macro defined): d access to 0x00800000 -> wb_mem_cyc_o stays 0, d_err_o=1 for exactly one cycle, one cycle after stb. With the macro undefined -> forwarded to memory.
- Async reset mid-burst: wb_rst_i low between edges -> wb_mem_cyc_o/stb_o drop to 0 without waiting for the clock.

Source files
------------

// File: rtl/wb_intercon_pkg.sv
// rtl/wb_intercon_pkg.sv - shared widths, grant states and burst tags for the CPU wishbone interconnect
package wb_intercon_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  // Which master currently owns the memory slave
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } grant_state_e;

  // Cycle type identifiers
  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

endpackage

// File: rtl/wb_intercon_arb_arbiter.sv
// rtl/wb_intercon_arb_arbiter.sv - cycle-locked two-master grant FSM (wb_arbiter_2)
module wb_arbiter_2
  import wb_intercon_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i_i,
  input  logic       cyc_d_i,
  output logic [1:0] gnt_o,
  output logic       gnt_chg_o
);

  grant_state_e state_q, state_d;

  // Grant register; reset drops ownership immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Owner keeps the bus while its cyc is high; on release the other master gets it, data wins from idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cyc_d_i)      state_d = GNT_D;
        else if (cyc_i_i) state_d = GNT_I;
      end
      GNT_I: begin
        if (!cyc_i_i) state_d = cyc_d_i ? GNT_D : IDLE;
      end
      GNT_D: begin
        if (!cyc_d_i) state_d = cyc_i_i ? GNT_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit 0 = instruction master, bit 1 = data master
  assign gnt_o     = {state_q == GNT_D, state_q == GNT_I};
  assign gnt_chg_o = (state_d != state_q);

endmodule

// File: rtl/wb_intercon_arb.sv
// rtl/wb_intercon_arb.sv - OR1200 I/D masters to main memory interconnect; WB_INTERCON_ADDR_CHECK_EN enables window decode
module wb_intercon_arb
  import wb_intercon_pkg::*;
#(
  parameter logic [WB_AW-1:0] MEM_BASE = 32'h0000_0000,
  parameter logic [WB_AW-1:0] MEM_SIZE = 32'h0080_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WB_AW-1:0] wb_or1200_i_adr_i,
  input  logic [WB_DW-1:0] wb_or1200_i_dat_i,
  input  logic [3:0]       wb_or1200_i_sel_i,
  input  logic             wb_or1200_i_we_i,
  input  logic             wb_or1200_i_cyc_i,
  input  logic             wb_or1200_i_stb_i,
  input  logic [2:0]       wb_or1200_i_cti_i,
  input  logic [1:0]       wb_or1200_i_bte_i,
  output logic [WB_DW-1:0] wb_or1200_i_dat_o,
  output logic             wb_or1200_i_ack_o,
  output logic             wb_or1200_i_err_o,
  output logic             wb_or1200_i_rty_o,
  input  logic [WB_AW-1:0] wb_or1200_d_adr_i,
  input  logic [WB_DW-1:0] wb_or1200_d_dat_i,
  input  logic [3:0]       wb_or1200_d_sel_i,
  input  logic             wb_or1200_d_we_i,
  input  logic             wb_or1200_d_cyc_i,
  input  logic             wb_or1200_d_stb_i,
  input  logic [2:0]       wb_or1200_d_cti_i,
  input  logic [1:0]       wb_or1200_d_bte_i,
  output logic [WB_DW-1:0] wb_or1200_d_dat_o,
  output logic             wb_or1200_d_ack_o,
  output logic             wb_or1200_d_err_o,
  output logic             wb_or1200_d_rty_o,
  output logic [WB_AW-1:0] wb_mem_adr_o,
  output logic [WB_DW-1:0] wb_mem_dat_o,
  output logic [3:0]       wb_mem_sel_o,
  output logic             wb_mem_we_o,
  output logic             wb_mem_cyc_o,
  output logic             wb_mem_stb_o,
  output logic [2:0]       wb_mem_cti_o,
  output logic [1:0]       wb_mem_bte_o,
  input  logic [WB_DW-1:0] wb_mem_dat_i,
  input  logic             wb_mem_ack_i,
  input  logic             wb_mem_err_i,
  input  logic             wb_mem_rty_i
);

  logic [1:0]       gnt;
  logic             gnt_chg;
  logic [WB_AW-1:0] own_adr;
  logic [WB_DW-1:0] own_dat;
  logic [3:0]       own_sel;
  logic             own_we, own_cyc, own_stb;
  logic [2:0]       own_cti;
  logic [1:0]       own_bte;
  logic             hit;
  logic             loc_err;

  wb_arbiter_2 u_arb (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_i),
    .cyc_i_i   (wb_or1200_i_cyc_i),
    .cyc_d_i   (wb_or1200_d_cyc_i),
    .gnt_o     (gnt),
    .gnt_chg_o (gnt_chg)
  );

  // Select the owner's request; with no owner everything toward memory is zero
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_cti = CLASSIC;
    own_bte = '0;
    if (gnt[1]) begin
      own_adr = wb_or1200_d_adr_i;
      own_dat = wb_or1200_d_dat_i;
      own_sel = wb_or1200_d_sel_i;
      own_we  = wb_or1200_d_we_i;
      own_cyc = wb_or1200_d_cyc_i;
      own_stb = wb_or1200_d_stb_i;
      own_cti = wb_or1200_d_cti_i;
      own_bte = wb_or1200_d_bte_i;
    end else if (gnt[0]) begin
      own_adr = wb_or1200_i_adr_i;
      own_dat = wb_or1200_i_dat_i;
      own_sel = wb_or1200_i_sel_i;
      own_we  = wb_or1200_i_we_i;
      own_cyc = wb_or1200_i_cyc_i;
      own_stb = wb_or1200_i_stb_i;
      own_cti = wb_or1200_i_cti_i;
      own_bte = wb_or1200_i_bte_i;
    end
  end

`ifdef WB_INTERCON_ADDR_CHECK_EN
  logic [WB_AW-1:0] offset;
  logic             err_r_q, err_r_d;

  // Unsigned offset from the base: addresses below the base wrap to huge values and miss
  assign offset  = own_adr - MEM_BASE;
  assign hit     = (offset < MEM_SIZE);
  assign loc_err = err_r_q;

  // One-cycle error pulse for a strobe outside the window; never carried across an ownership change
  always_comb begin
    err_r_d = 1'b0;
    if (!gnt_chg) err_r_d = own_cyc & own_stb & ~hit & ~err_r_q;
  end

  // Local error register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) err_r_q <= 1'b0;
    else           err_r_q <= err_r_d;
  end
`else
  logic unused_cfg;

  assign hit        = 1'b1;
  assign loc_err    = 1'b0;
  assign unused_cfg = ^{MEM_BASE, MEM_SIZE, gnt_chg};
`endif

  assign wb_mem_adr_o = own_adr;
  assign wb_mem_dat_o = own_dat;
  assign wb_mem_sel_o = own_sel;
  assign wb_mem_we_o  = own_we;
  assign wb_mem_cyc_o = own_cyc & hit;
  assign wb_mem_stb_o = own_stb & hit;
  assign wb_mem_cti_o = own_cti;
  assign wb_mem_bte_o = own_bte;

  // Read data goes to both masters; terminations only to the owner
  assign wb_or1200_i_dat_o = wb_mem_dat_i;
  assign wb_or1200_d_dat_o = wb_mem_dat_i;
  assign wb_or1200_i_ack_o = gnt[0] & wb_mem_ack_i;
  assign wb_or1200_i_err_o = gnt[0] & (wb_mem_err_i | loc_err);
  assign wb_or1200_i_rty_o = gnt[0] & wb_mem_rty_i;
  assign wb_or1200_d_ack_o = gnt[1] & wb_mem_ack_i;
  assign wb_or1200_d_err_o = gnt[1] & (wb_mem_err_i | loc_err);
  assign wb_or1200_d_rty_o = gnt[1] & wb_mem_rty_i;

endmodule

// File: tb/tb_wb_intercon_arb.sv
// tb/tb_wb_intercon_arb.sv - self-checking bench for wb_intercon_arb; honours WB_INTERCON_ADDR_CHECK_EN
module tb_wb_intercon_arb;
  import wb_intercon_pkg::*;

  localparam logic [31:0] TB_BASE = 32'h0000_0000;
  localparam logic [31:0] TB_SIZE = 32'h0080_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] i_adr, i_dat, d_adr, d_dat, mem_dat_i;
  logic [3:0]  i_sel, d_sel;
  logic        i_we, i_cyc, i_stb, d_we, d_cyc, d_stb;
  logic [2:0]  i_cti, d_cti;
  logic [1:0]  i_bte, d_bte;
  logic        mem_ack_i, mem_err_i, mem_rty_i;

  logic [31:0] i_dat_o, d_dat_o, mem_adr, mem_dat_o;
  logic        i_ack, i_err, i_rty, d_ack, d_err, d_rty;
  logic [3:0]  mem_sel;
  logic        mem_we, mem_cyc, mem_stb;
  logic [2:0]  mem_cti;
  logic [1:0]  mem_bte;

  int errors = 0;
  int checks = 0;

  wb_intercon_arb #(.MEM_BASE(TB_BASE), .MEM_SIZE(TB_SIZE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wb_or1200_i_adr_i(i_adr), .wb_or1200_i_dat_i(i_dat), .wb_or1200_i_sel_i(i_sel),
    .wb_or1200_i_we_i(i_we), .wb_or1200_i_cyc_i(i_cyc), .wb_or1200_i_stb_i(i_stb),
    .wb_or1200_i_cti_i(i_cti), .wb_or1200_i_bte_i(i_bte),
    .wb_or1200_i_dat_o(i_dat_o), .wb_or1200_i_ack_o(i_ack), .wb_or1200_i_err_o(i_err),
    .wb_or1200_i_rty_o(i_rty),
    .wb_or1200_d_adr_i(d_adr), .wb_or1200_d_dat_i(d_dat), .wb_or1200_d_sel_i(d_sel),
    .wb_or1200_d_we_i(d_we), .wb_or1200_d_cyc_i(d_cyc), .wb_or1200_d_stb_i(d_stb),
    .wb_or1200_d_cti_i(d_cti), .wb_or1200_d_bte_i(d_bte),
    .wb_or1200_d_dat_o(d_dat_o), .wb_or1200_d_ack_o(d_ack), .wb_or1200_d_err_o(d_err),
    .wb_or1200_d_rty_o(d_rty),
    .wb_mem_adr_o(mem_adr), .wb_mem_dat_o(mem_dat_o), .wb_mem_sel_o(mem_sel),
    .wb_mem_we_o(mem_we), .wb_mem_cyc_o(mem_cyc), .wb_mem_stb_o(mem_stb),
    .wb_mem_cti_o(mem_cti), .wb_mem_bte_o(mem_bte),
    .wb_mem_dat_i(mem_dat_i), .wb_mem_ack_i(mem_ack_i), .wb_mem_err_i(mem_err_i),
    .wb_mem_rty_i(mem_rty_i)
  );

  // Reference model: owner 0 = nobody, 1 = instruction, 2 = data
  int m_owner = 0;
  int m_next;
  bit m_err = 1'b0;

  function automatic bit exp_hit(input logic [31:0] a);
`ifdef WB_INTERCON_ADDR_CHECK_EN
    longint unsigned aa, lo, hi;
    aa = longint'(a);
    lo = longint'(TB_BASE);
    hi = lo + longint'(TB_SIZE);
    return (aa >= lo) && (aa < hi);
`else
    return a == a;
`endif
  endfunction

  logic [31:0] o_adr, o_dat;
  logic [3:0]  o_sel;
  logic        o_we, o_cyc, o_stb;
  logic [2:0]  o_cti;
  logic [1:0]  o_bte;

  always @* begin
    {o_adr, o_dat, o_sel, o_we, o_cyc, o_stb, o_cti, o_bte} = '0;
    if (m_owner == 1) {o_adr, o_dat, o_sel, o_we, o_cyc, o_stb, o_cti, o_bte} =
        {i_adr, i_dat, i_sel, i_we, i_cyc, i_stb, i_cti, i_bte};
    if (m_owner == 2) {o_adr, o_dat, o_sel, o_we, o_cyc, o_stb, o_cti, o_bte} =
        {d_adr, d_dat, d_sel, d_we, d_cyc, d_stb, d_cti, d_bte};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0;
      m_err   = 1'b0;
    end else begin
      if (m_owner != 0 && o_cyc) m_next = m_owner;
      else if (d_cyc)            m_next = 2;
      else if (i_cyc)            m_next = 1;
      else                       m_next = 0;
`ifdef WB_INTERCON_ADDR_CHECK_EN
      m_err = (m_next == m_owner) && !m_err && o_cyc && o_stb && !exp_hit(o_adr);
`endif
      m_owner = m_next;
    end
  end

  logic [75:0] e_fwd, a_fwd;
  logic [69:0] e_ret, a_ret;
  bit          e_hit;

  always @* begin
    e_hit = exp_hit(o_adr);
    e_fwd = {o_adr, o_dat, o_sel, o_we, o_cyc && e_hit, o_stb && e_hit, o_cti, o_bte};
    e_ret = {mem_dat_i, m_owner == 1 && mem_ack_i, m_owner == 1 && (mem_err_i || m_err),
             m_owner == 1 && mem_rty_i,
             mem_dat_i, m_owner == 2 && mem_ack_i, m_owner == 2 && (mem_err_i || m_err),
             m_owner == 2 && mem_rty_i};
  end

  assign a_fwd = {mem_adr, mem_dat_o, mem_sel, mem_we, mem_cyc, mem_stb, mem_cti, mem_bte};
  assign a_ret = {i_dat_o, i_ack, i_err, i_rty, d_dat_o, d_ack, d_err, d_rty};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    {i_adr, i_dat, i_sel, i_we, i_cyc, i_stb, i_cti, i_bte} = '0;
    {d_adr, d_dat, d_sel, d_we, d_cyc, d_stb, d_cti, d_bte} = '0;
    {mem_dat_i, mem_ack_i, mem_err_i, mem_rty_i} = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    i_cyc = 1; i_stb = 1; i_adr = 32'h80;
    d_cyc = 1; d_stb = 1; d_adr = 32'h40;
    mem_ack_i = 1; mem_err_i = 1; mem_rty_i = 1;
    repeat (2) @(negedge clk);
    checks++; if (mem_cyc !== 1'b0) begin errors++; $display("FAIL reset_mem_cyc got=%b exp=0", mem_cyc); end
    checks++; if (mem_stb !== 1'b0) begin errors++; $display("FAIL reset_mem_stb got=%b exp=0", mem_stb); end
    checks++; if ({i_ack, i_err, i_rty, d_ack, d_err, d_rty} !== 6'b0) begin
      errors++; $display("FAIL reset_terms got=%b exp=000000", {i_ack, i_err, i_rty, d_ack, d_err, d_rty}); end
    rst_n = 1'b1;
    tick();
    checks++; if (mem_cyc !== 1'b1 || mem_adr !== 32'h40) begin
      errors++; $display("FAIL reset_first_grant got cyc=%b adr=%h exp cyc=1 adr=00000040", mem_cyc, mem_adr); end
    checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack_route got d=%b i=%b exp d=1 i=0", d_ack, i_ack); end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_instr_read();
    i_cyc = 1; i_stb = 1; i_adr = 32'h100; i_sel = 4'hF;
    #3;
    checks++; if (mem_stb !== 1'b0) begin errors++; $display("FAIL iread_latency got stb=%b exp=0", mem_stb); end
    tick();
    checks++; if (mem_adr !== 32'h100 || mem_stb !== 1'b1) begin
      errors++; $display("FAIL iread_fwd got adr=%h stb=%b exp adr=00000100 stb=1", mem_adr, mem_stb); end
    mem_ack_i = 1; mem_dat_i = 32'hDEADBEEF;
    #1;
    checks++; if (i_ack !== 1'b1 || i_dat_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL iread_ret got ack=%b dat=%h exp ack=1 dat=deadbeef", i_ack, i_dat_o); end
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL iread_d_ack got=%b exp=0", d_ack); end
    tick();
    idle_all();
    tick(); tick();
  endtask

  task automatic test_contention();
    i_cyc = 1; i_stb = 1; i_adr = 32'h300;
    d_cyc = 1; d_stb = 1; d_adr = 32'h400;
    tick();
    checks++; if (mem_adr !== 32'h400) begin errors++; $display("FAIL cont_tie got adr=%h exp=00000400", mem_adr); end
    mem_ack_i = 1;
    #1;
    checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
      errors++; $display("FAIL cont_ack got d=%b i=%b exp d=1 i=0", d_ack, i_ack); end
    tick();
    d_cyc = 0; d_stb = 0; mem_ack_i = 0;
    tick();
    checks++; if (mem_adr !== 32'h300 || mem_cyc !== 1'b1) begin
      errors++; $display("FAIL cont_handover got adr=%h cyc=%b exp adr=00000300 cyc=1", mem_adr, mem_cyc); end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_burst_lock();
    logic [2:0] ecti;
    i_cyc = 1; i_stb = 1; i_adr = 32'h500;
    d_cyc = 1; d_stb = 1; d_adr = 32'h2000; d_cti = INCR;
    tick();
    for (int k = 0; k < 4; k++) begin
      ecti = (k == 3) ? EOB : INCR;
      d_adr = 32'h2000 + 32'(4 * k); d_cti = ecti; mem_ack_i = 1;
      #2;
      checks++; if (mem_adr !== 32'h2000 + 32'(4 * k) || mem_cti !== ecti || d_ack !== 1'b1 || i_ack !== 1'b0) begin
        errors++; $display("FAIL burst_beat%0d got adr=%h cti=%b dack=%b iack=%b exp adr=%h cti=%b dack=1 iack=0",
                           k, mem_adr, mem_cti, d_ack, i_ack, 32'h2000 + 32'(4 * k), ecti); end
      tick();
    end
    d_cyc = 0; d_stb = 0; d_cti = CLASSIC; mem_ack_i = 0;
    tick();
    checks++; if (mem_adr !== 32'h500 || mem_cyc !== 1'b1) begin
      errors++; $display("FAIL burst_release got adr=%h cyc=%b exp adr=00000500 cyc=1", mem_adr, mem_cyc); end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_out_of_range();
    d_cyc = 1; d_stb = 1; d_adr = 32'h0080_0000;
    tick();
    #1;
`ifdef WB_INTERCON_ADDR_CHECK_EN
    checks++; if (mem_cyc !== 1'b0 || mem_stb !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL oor_blocked got cyc=%b stb=%b err=%b exp 0 0 0", mem_cyc, mem_stb, d_err); end
    tick(); #1;
    checks++; if (d_err !== 1'b1 || mem_cyc !== 1'b0) begin
      errors++; $display("FAIL oor_err_pulse got err=%b cyc=%b exp err=1 cyc=0", d_err, mem_cyc); end
    tick(); #1;
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL oor_err_one_cycle got=%b exp=0", d_err); end
`else
    checks++; if (mem_cyc !== 1'b1 || mem_adr !== 32'h0080_0000 || d_err !== 1'b0) begin
      errors++; $display("FAIL oor_forward got cyc=%b adr=%h err=%b exp cyc=1 adr=00800000 err=0",
                         mem_cyc, mem_adr, d_err); end
`endif
    idle_all();
    tick(); tick();
  endtask

  task automatic test_async_reset();
    d_cyc = 1; d_stb = 1; d_adr = 32'h3000; d_cti = INCR;
    tick();
    checks++; if (mem_cyc !== 1'b1) begin errors++; $display("FAIL areset_pre got cyc=%b exp=1", mem_cyc); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_cyc !== 1'b0 || mem_stb !== 1'b0) begin
      errors++; $display("FAIL areset_drop got cyc=%b stb=%b exp 0 0", mem_cyc, mem_stb); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (mem_cyc !== 1'b1 || mem_adr !== 32'h3000) begin
      errors++; $display("FAIL areset_restart got cyc=%b adr=%h exp cyc=1 adr=00003000", mem_cyc, mem_adr); end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [31:0] pick [4];
    pick[0] = 32'h007F_FFFC; pick[1] = 32'h0080_0000; pick[2] = 32'hFFFF_FFFC; pick[3] = 32'h0000_0000;
    for (int n = 0; n < 400; n++) begin
      tick();
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 3) == 0) i_cyc = ~i_cyc;
      if ($urandom_range(0, 3) == 0) d_cyc = ~d_cyc;
      i_stb = i_cyc & ($urandom_range(0, 3) != 0);
      d_stb = d_cyc & ($urandom_range(0, 3) != 0);
      i_adr = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : ($urandom & 32'h00FF_FFFC);
      d_adr = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : ($urandom & 32'h00FF_FFFC);
      i_dat = $urandom; d_dat = $urandom;
      i_sel = 4'($urandom); d_sel = 4'($urandom);
      i_we = 1'($urandom); d_we = 1'($urandom);
      i_cti = 3'($urandom); d_cti = 3'($urandom);
      i_bte = 2'($urandom); d_bte = 2'($urandom);
      mem_dat_i = $urandom;
      mem_ack_i = 1'($urandom); mem_err_i = ($urandom_range(0, 7) == 0); mem_rty_i = ($urandom_range(0, 7) == 0);
      #3;
      checks++; if (a_fwd !== e_fwd) begin
        errors++; $display("FAIL rand_fwd n=%0d got=%h exp=%h", n, a_fwd, e_fwd); end
      checks++; if (a_ret !== e_ret) begin
        errors++; $display("FAIL rand_ret n=%0d got=%h exp=%h", n, a_ret, e_ret); end
    end
    rst_n = 1'b1;
    idle_all();
    tick(); tick();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_instr_read();
    test_contention();
    test_burst_lock();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
